// File: rtl/megaphone_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : megaphone_uart_pkg
//  Description : Types and constants shared by the MEGAphone UART blocks
//                (uart_tx / uart_rx_buffered).
//                uart_rx_state_t   receiver FSM state encoding
//                BIT_TMR_2M_48M    BIT_TMR_MAX for 2 Mbps from a 48 MHz clock
//  Revision    : 1.0  initial release
// ============================================================================
package megaphone_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    // Cycles per bit minus one: 48 MHz / 2 Mbps = 24 cycles.
    localparam logic [23:0] BIT_TMR_2M_48M = 24'd23;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Synchronous first-word-fall-through FIFO with a registered
//                head output. A push into a full FIFO is ignored unless a pop
//                happens in the same cycle; a pop from an empty FIFO is ignored.
//  Ports       : clk      clock (rising edge)
//                rst      synchronous active-high reset (flushes FIFO)
//                push_i   write din_i
//                din_i    write data
//                pop_i    remove head (ignored when empty)
//                full_o   FIFO holds DEPTH entries
//                empty_o  FIFO holds no entries
//                head_o   oldest entry; meaningful only when !empty_o
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;

    assign pop_ok  = pop_i && !empty_o;
    // When full, a simultaneous pop frees the slot being written.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rd_next = rd_ptr_q + PTR_W'(1);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // The head register is loaded one cycle ahead so the output is a flop.
    // On pop with more than one entry the next entry is already in memory;
    // with exactly one entry the only candidate is the word being pushed.
    always_comb begin
        head_d = head_q;
        if (pop_ok) begin
            if (count_q != CNT_W'(1)) begin
                head_d = mem_q[rd_next];
            end else if (push_ok) begin
                head_d = din_i;
            end
        end else if (push_ok && empty_o) begin
            head_d = din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_next;
            end
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_buffered
//  Description : 8N1 UART receiver with runtime bit timer, 2-flop input
//                synchroniser, mid-bit sampling, framing/overflow detection
//                and a byte FIFO with a valid/ready read port.
//  Ports       : clk48          system clock, rising edge
//                reset          synchronous active-high reset
//                BIT_TMR_MAX    cycles per bit - 1, latched at start detect
//                UART_RX        asynchronous serial input, idle high
//                rx_data        FIFO head byte (valid when rx_valid)
//                rx_valid       FIFO non-empty
//                rx_ready       pop head when rx_valid & rx_ready
//                framing_error  one-cycle pulse, stop bit sampled low
//                overflow       sticky, byte dropped on full FIFO
//                clear_errors   clears overflow (a same-cycle drop wins)
//                rx_busy        FSM not idle
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_buffered
    import megaphone_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TMR_WIDTH  = 24
) (
    input  logic                 clk48,
    input  logic                 reset,
    input  logic [TMR_WIDTH-1:0] BIT_TMR_MAX,
    input  logic                 UART_RX,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_error,
    output logic                 overflow,
    input  logic                 clear_errors,
    output logic                 rx_busy
);

    uart_rx_state_t       state_q, state_d;
    logic                 rx_meta_q;
    logic                 rx_s_q;
    logic [TMR_WIDTH-1:0] tmr_q, tmr_d;
    logic [TMR_WIDTH-1:0] bit_max_q, bit_max_d;
    logic [TMR_WIDTH-1:0] half;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 fe_q, fe_d;
    logic                 ovf_q;
    logic                 push;
    logic                 drop;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign half = bit_max_q >> 1;

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_max_d = bit_max_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        fe_d      = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (!rx_s_q) begin
                    state_d   = START;
                    bit_max_d = BIT_TMR_MAX;
                end
            end
            START: begin
                // Re-check the start bit half a bit later so every later
                // sample lands at a bit centre; a high line here was a glitch.
                if (tmr_q == half) begin
                    tmr_d = '0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_WIDTH'(1);
                end
            end
            DATA: begin
                if (tmr_q == bit_max_q) begin
                    tmr_d     = '0;
                    shreg_d   = {rx_s_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_WIDTH'(1);
                end
            end
            STOP: begin
                if (tmr_q == bit_max_q) begin
                    tmr_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_WIDTH'(1);
                end
            end
            BREAK: begin
                // Hold off start detection until the line returns high.
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk48) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            tmr_q     <= '0;
            bit_max_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            fe_q      <= 1'b0;
        end else begin
            rx_meta_q <= UART_RX;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_max_q <= bit_max_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            fe_q      <= fe_d;
        end
    end

    // A full FIFO is never empty, so the only way to make room is rx_ready.
    assign drop = push && fifo_full && !rx_ready;

    always_ff @(posedge clk48) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (clear_errors) begin
            ovf_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk48),
        .rst     (reset),
        .push_i  (push),
        .din_i   (shreg_q),
        .pop_i   (rx_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (rx_data)
    );

    assign rx_valid      = !fifo_empty;
    assign framing_error = fe_q;
    assign overflow      = ovf_q;
    assign rx_busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_buffered
//  Description : Directed self-checking bench for uart_rx_buffered at
//                BIT_TMR_MAX = 23 (24 cycles per bit).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_buffered;
    import megaphone_uart_pkg::*;

    localparam int BIT_CYC = 24;

    logic        clk48 = 1'b0;
    logic        reset;
    logic [23:0] BIT_TMR_MAX;
    logic        UART_RX;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        framing_error;
    logic        overflow;
    logic        clear_errors;
    logic        rx_busy;

    int          n_checks = 0;
    int          n_errors = 0;
    int          fe_cnt   = 0;
    logic [7:0]  popped[$];

    uart_rx_buffered #(
        .FIFO_DEPTH (16),
        .TMR_WIDTH  (24)
    ) dut (
        .clk48         (clk48),
        .reset         (reset),
        .BIT_TMR_MAX   (BIT_TMR_MAX),
        .UART_RX       (UART_RX),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .framing_error (framing_error),
        .overflow      (overflow),
        .clear_errors  (clear_errors),
        .rx_busy       (rx_busy)
    );

    always #10 clk48 = ~clk48;

    // A pop happens at the posedge following a negedge with valid & ready.
    always @(negedge clk48) begin
        if (!reset && rx_valid && rx_ready) popped.push_back(rx_data);
        if (!reset && framing_error) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk48);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_lvl);
        UART_RX = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            tick(BIT_CYC);
        end
        UART_RX = stop_lvl;
        tick(BIT_CYC);
        UART_RX = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        string msg;
        int    base;
        int    fe_base;
        int    guard;

        reset        = 1'b1;
        BIT_TMR_MAX  = BIT_TMR_2M_48M;
        UART_RX      = 1'b1;
        rx_ready     = 1'b0;
        clear_errors = 1'b0;
        tick(4);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_fe", 32'(framing_error), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        reset = 1'b0;
        tick(BIT_CYC);

        // 1: single byte 0x4D held in the FIFO
        send_frame(8'h4D, 1'b1);
        tick(BIT_CYC);
        check("t1_valid", 32'(rx_valid), 32'd1);
        check("t1_data", 32'(rx_data), 32'h4D);
        check("t1_ovf", 32'(overflow), 32'd0);
        check("t1_fe", 32'(fe_cnt), 32'd0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("t1_one_push", 32'(rx_valid), 32'd0);

        // 2: 16 back-to-back characters drained as they arrive
        msg  = "MEGAphone CTL0\r\n";
        base = popped.size();
        rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_frame(msg[i], 1'b1);
        tick(2 * BIT_CYC);
        rx_ready = 1'b0;
        check("t2_count", 32'(popped.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < popped.size())
                check($sformatf("t2_byte%0d", i), 32'(popped[base + i]), 32'(msg[i]));
            else
                check($sformatf("t2_byte%0d", i), 32'hFFFF_FFFF, 32'(msg[i]));
        end
        check("t2_ovf", 32'(overflow), 32'd0);

        // 3: 8-cycle low glitch on an idle line
        fe_base = fe_cnt;
        UART_RX = 1'b0;
        tick(6);
        check("t3_busy_in", 32'(rx_busy), 32'd1);
        tick(2);
        UART_RX = 1'b1;
        tick(2 * BIT_CYC);
        check("t3_busy_out", 32'(rx_busy), 32'd0);
        check("t3_valid", 32'(rx_valid), 32'd0);
        check("t3_fe", 32'(fe_cnt - fe_base), 32'd0);

        // 4: 0x55 with a low stop bit, then line released
        fe_base = fe_cnt;
        send_frame(8'h55, 1'b0);
        tick(2 * BIT_CYC);
        check("t4_fe_pulses", 32'(fe_cnt - fe_base), 32'd1);
        check("t4_valid", 32'(rx_valid), 32'd0);
        check("t4_busy", 32'(rx_busy), 32'd0);

        // 5: 17 bytes into a 16-deep FIFO with no reader
        for (int i = 0; i < 17; i++) send_frame(8'h10 + 8'(i), 1'b1);
        tick(BIT_CYC);
        check("t5_ovf_set", 32'(overflow), 32'd1);
        base     = popped.size();
        rx_ready = 1'b1;
        guard    = 0;
        while (rx_valid && guard < 40) begin
            tick(1);
            guard++;
        end
        rx_ready = 1'b0;
        tick(1);
        check("t5_drained", 32'(rx_valid), 32'd0);
        check("t5_count", 32'(popped.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < popped.size())
                check($sformatf("t5_byte%0d", i), 32'(popped[base + i]), 32'h10 + 32'(i));
            else
                check($sformatf("t5_byte%0d", i), 32'hFFFF_FFFF, 32'h10 + 32'(i));
        end
        check("t5_ovf_hold", 32'(overflow), 32'd1);
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
        check("t5_ovf_clr", 32'(overflow), 32'd0);

        // 6: reset in the middle of data bit 4 with one byte queued
        send_frame(8'h3C, 1'b1);
        tick(BIT_CYC);
        check("t6_pre_valid", 32'(rx_valid), 32'd1);
        UART_RX = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            UART_RX = 1'b0;
            tick(BIT_CYC);
        end
        UART_RX = 1'b1;
        tick(BIT_CYC / 2);
        check("t6_busy_mid", 32'(rx_busy), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_valid", 32'(rx_valid), 32'd0);
        check("t6_busy", 32'(rx_busy), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        tick(3 * BIT_CYC);
        send_frame(8'hA5, 1'b1);
        tick(BIT_CYC);
        check("t6_a5_valid", 32'(rx_valid), 32'd1);
        check("t6_a5_data", 32'(rx_data), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
